// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1R1W SRAM with clear engine.
// Holds the FSM state enum, the read-source select and the byte merge.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_BYP  = 2'd2,
    SRC_INIT = 2'd3
  } rd_src_t;

  localparam int MAX_W = 1024;
  localparam int MAX_B = MAX_W / 8;

  // Replace each byte of old_w whose enable is set with the byte of new_w.
  // Callers size operands up to MAX_W and cast the result back down.
  function automatic logic [MAX_W-1:0] be_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_B-1:0] be
  );
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_B; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_1r1w_core.sv
// Bare storage array: one byte-enabled write port, one synchronous read.
// Ports: clk, we/waddr/wdata/wbe (write), re/raddr/rdata (read, 1 cycle).
module sram_1r1w_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read sees the pre-write word on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sram_1r1w_clr.sv
// Simple-dual-port SRAM with clear engine, range checks and RDW bypass.
// Ports: clk, rst, init_req/init_busy, wr_* write port, rd_* read port.
module sram_1r1w_clr
  import sram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 7,
  parameter int                DEPTH    = 128,
  parameter int                WR_FIRST = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_req,
  output logic                init_busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    unique case (state)
      CLEAR: begin
        clr_ptr_nx = clr_ptr + 1'b1;
        if (clr_ptr == LAST) state_nx = READY;
      end
      READY: begin
        if (init_req) begin
          state_nx   = CLEAR;
          clr_ptr_nx = '0;
        end
      end
    endcase
  end

  logic ready, acc, wr_in, rd_in, wr_ok, rd_ok, hit;

  assign ready     = (state == READY);
  assign init_busy = ~ready;
  // The cycle that accepts init_req also drops both ports.
  assign acc   = ready & ~init_req;
  assign wr_in = {1'b0, wr_addr} < DEPTH_L;
  assign rd_in = {1'b0, rd_addr} < DEPTH_L;
  assign wr_ok = acc & wr_en & wr_in;
  assign rd_ok = acc & rd_en;
  assign hit   = wr_ok & rd_in & (wr_addr == rd_addr);

  logic              c_we;
  logic [ADDR_W-1:0] c_waddr;
  logic [DATA_W-1:0] c_wdata;
  logic [NB-1:0]     c_wbe;
  logic [DATA_W-1:0] c_rdata;

  assign c_we    = ~ready | wr_ok;
  assign c_waddr = ready ? wr_addr : clr_ptr;
  assign c_wdata = ready ? wr_data : INIT_VAL;
  assign c_wbe   = ready ? wr_be : {NB{1'b1}};

  sram_1r1w_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk   (clk),
    .we    (c_we),
    .waddr (c_waddr),
    .wdata (c_wdata),
    .wbe   (c_wbe),
    .re    (rd_ok & rd_in),
    .raddr (rd_addr),
    .rdata (c_rdata)
  );

  rd_src_t           src;
  logic [DATA_W-1:0] byp_data;
  logic [NB-1:0]     byp_be;

  // The output mux is steered by registered selects so rd_data
  // holds between reads and drops to zero the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      src      <= SRC_ZERO;
      byp_data <= '0;
      byp_be   <= '0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        if (!rd_in) begin
          src <= SRC_INIT;
        end else if ((WR_FIRST != 0) && hit) begin
          src      <= SRC_BYP;
          byp_data <= wr_data;
          byp_be   <= wr_be;
        end else begin
          src <= SRC_MEM;
        end
      end
    end
  end

  // Bypass merges the old word (from the array) with the captured write.
  always_comb begin
    rd_data = '0;
    unique case (src)
      SRC_ZERO: rd_data = '0;
      SRC_MEM:  rd_data = c_rdata;
      SRC_BYP:  rd_data = DATA_W'(be_merge(MAX_W'(c_rdata),
                                           MAX_W'(byp_data),
                                           MAX_B'(byp_be)));
      SRC_INIT: rd_data = INIT_VAL;
    endcase
  end

endmodule
